// File: rtl/ecmp_sched_if.sv
// ecmp_sched_if: bundle of request, divider and response signals of the
// ECMP next-hop scheduler.
//   req_*   : per-requester flat vectors (requester i at lane i)
//   div_*   : operands to / remainder from the shared external divider
//   resp_*  : single result channel with valid/ready handshake
// slave  = scheduler side, master = requesters + divider + downstream.
interface ecmp_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int BASE_W  = 8
);
  logic [NUM_REQ-1:0]        req_vld;
  logic [NUM_REQ-1:0]        req_rdy;
  logic [4*NUM_REQ-1:0]      req_hash;
  logic [4*NUM_REQ-1:0]      req_nh_count;
  logic [BASE_W*NUM_REQ-1:0] req_nh_base;
  logic [3:0]                div_dividend;
  logic [3:0]                div_divisor;
  logic [3:0]                div_remainder;
  logic                      resp_vld;
  logic                      resp_rdy;
  logic [2:0]                resp_id;
  logic [BASE_W-1:0]         resp_nh;
  logic                      resp_err;

  modport slave (
    input  req_vld, req_hash, req_nh_count, req_nh_base, div_remainder, resp_rdy,
    output req_rdy, div_dividend, div_divisor, resp_vld, resp_id, resp_nh, resp_err
  );

  modport master (
    output req_vld, req_hash, req_nh_count, req_nh_base, div_remainder, resp_rdy,
    input  req_rdy, div_dividend, div_divisor, resp_vld, resp_id, resp_nh, resp_err
  );
endinterface

// File: rtl/ecmp_sched.sv
// ecmp_sched: picks an equal-cost next hop for one requester at a time,
// sharing a single external divider (hash mod nh_count).
//   clk   : single clock, rising edge
//   reset : asynchronous, active low
//   bus   : ecmp_sched_if.slave (requests, divider operands/result, response)
// Flow: IDLE (round-robin grant, req_rdy pulse) -> ISSUE (operands out)
//       -> CAPT (remainder sampled, result registered) -> RESP (hold until
//       accepted). One transaction in flight; grants are >= 4 cycles apart.
module ecmp_sched #(
  parameter int NUM_REQ = 4,
  parameter int BASE_W  = 8
) (
  input  logic          clk,
  input  logic          reset,
  ecmp_sched_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  state_t            state;
  logic [2:0]        rr_ptr;    // first requester searched at next grant
  logic [2:0]        id_q;
  logic [3:0]        hash_q;
  logic [3:0]        cnt_q;
  logic [BASE_W-1:0] base_q;
  logic              resp_vld_q;
  logic              resp_err_q;
  logic [2:0]        resp_id_q;
  logic [BASE_W-1:0] resp_nh_q;

  // Round-robin: lowest valid index >= rr_ptr, else lowest valid overall
  // (the wrap). Descending loop lets the lowest match overwrite.
  logic              hit_hi, hit_lo, gnt_any;
  logic [2:0]        id_hi, id_lo, gnt_id;
  logic [3:0]        hash_sel, cnt_sel;
  logic [BASE_W-1:0] base_sel;

  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    id_hi  = '0;
    id_lo  = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (bus.req_vld[k]) begin
        hit_lo = 1'b1;
        id_lo  = 3'(k);
        if (3'(k) >= rr_ptr) begin
          hit_hi = 1'b1;
          id_hi  = 3'(k);
        end
      end
    end
    gnt_any = hit_lo;
    gnt_id  = hit_hi ? id_hi : id_lo;
  end

  // Operand mux for the granted requester.
  always_comb begin
    hash_sel = '0;
    cnt_sel  = '0;
    base_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_id == 3'(k)) begin
        hash_sel = bus.req_hash[4*k +: 4];
        cnt_sel  = bus.req_nh_count[4*k +: 4];
        base_sel = bus.req_nh_base[BASE_W*k +: BASE_W];
      end
    end
  end

  // Grant pulse is combinational in IDLE; gated by reset so nothing is
  // accepted before the first edge after release.
  logic grant_en;
  assign grant_en = reset && (state == IDLE) && gnt_any;

  always_comb begin
    bus.req_rdy = '0;
    for (int k = 0; k < NUM_REQ; k++)
      bus.req_rdy[k] = grant_en && (gnt_id == 3'(k));
  end

  // Divider may return out-of-range values; clamp to 0. count==0 also
  // forces r=0 so the result is the base itself.
  logic [3:0] r_fix;
  assign r_fix = ((cnt_q == 4'd0) || (bus.div_remainder >= cnt_q)) ? 4'd0 : bus.div_remainder;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      id_q       <= '0;
      hash_q     <= '0;
      cnt_q      <= '0;
      base_q     <= '0;
      resp_vld_q <= 1'b0;
      resp_err_q <= 1'b0;
      resp_id_q  <= '0;
      resp_nh_q  <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          id_q   <= gnt_id;
          hash_q <= hash_sel;
          cnt_q  <= cnt_sel;
          base_q <= base_sel;
          rr_ptr <= (gnt_id == 3'(NUM_REQ-1)) ? 3'd0 : gnt_id + 3'd1;
          state  <= ISSUE;
        end
        ISSUE: state <= CAPT;
        CAPT: begin
          resp_nh_q  <= base_q + BASE_W'(r_fix);
          resp_err_q <= (cnt_q == 4'd0);
          resp_id_q  <= id_q;
          resp_vld_q <= 1'b1;
          state      <= RESP;
        end
        RESP: if (bus.resp_rdy) begin
          resp_vld_q <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operands come straight from the latched registers: stable ISSUE..CAPT.
  assign bus.div_dividend = hash_q;
  assign bus.div_divisor  = cnt_q;
  assign bus.resp_vld     = resp_vld_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.resp_id      = resp_id_q;
  assign bus.resp_nh      = resp_nh_q;
endmodule

// File: tb/tb_ecmp_sched.sv
module tb_ecmp_sched;
  localparam int NUM_REQ = 4;
  localparam int BASE_W  = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ecmp_sched_if #(.NUM_REQ(NUM_REQ), .BASE_W(BASE_W)) bus ();
  ecmp_sched #(.NUM_REQ(NUM_REQ), .BASE_W(BASE_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  // External divider: registered, optionally forced to a bogus value.
  logic       frc_en = 1'b0;
  logic [3:0] frc_val = 4'h0;
  always @(posedge clk)
    bus.div_remainder <= frc_en ? frc_val :
                         (bus.div_divisor == 4'd0) ? 4'h0 : bus.div_dividend % bus.div_divisor;

  typedef struct { logic [2:0] id; logic [7:0] nh; logic err; int gcyc; } exp_t;
  exp_t sbq[$];
  int   gnt_ids[$];
  int   gnt_cyc[$];
  int   n_cmp = 0, n_err = 0, cyc_n = 0;
  logic prev_vld = 1'b0;
  logic [7:0] hold_nh;
  logic [2:0] hold_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] h, input logic [3:0] c, input logic [7:0] b);
    bus.req_hash[4*i +: 4]     = h;
    bus.req_nh_count[4*i +: 4] = c;
    bus.req_nh_base[8*i +: 8]  = b;
  endtask

  // Scoreboard: push prediction on grant, pop/compare on response handshake.
  task automatic observe();
    int g;
    exp_t e;
    logic [3:0] h, c, raw;
    logic [7:0] b;
    g = 0;
    if (bus.req_rdy != '0) begin
      for (int i = 0; i < NUM_REQ; i++) if (bus.req_rdy[i]) g = i;
      chk("req_rdy_onehot", $countones(bus.req_rdy), 1);
      h = bus.req_hash[4*g +: 4];
      c = bus.req_nh_count[4*g +: 4];
      b = bus.req_nh_base[8*g +: 8];
      raw = frc_en ? frc_val : (c == 4'd0) ? 4'd0 : h % c;
      e.id   = 3'(g);
      e.err  = (c == 4'd0);
      e.nh   = (c == 4'd0 || raw >= c) ? b : b + {4'h0, raw};
      e.gcyc = cyc_n;
      sbq.push_back(e);
      gnt_ids.push_back(g);
      gnt_cyc.push_back(cyc_n);
    end
    if (bus.resp_vld && !prev_vld) begin
      chk("resp_pending", sbq.size(), 1);
      if (sbq.size() > 0) chk("resp_latency", cyc_n, sbq[0].gcyc + 3);
    end
    if (bus.resp_vld && bus.resp_rdy) begin
      chk("sb_nonempty", sbq.size(), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("resp_id", bus.resp_id, e.id);
        chk("resp_nh", bus.resp_nh, e.nh);
        chk("resp_err", bus.resp_err, e.err);
      end
    end
    prev_vld = bus.resp_vld;
  endtask

  // Entered at posedge+1 with inputs set; leaves at next posedge+1.
  task automatic step();
    #1;
    observe();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && sbq.size() != 0; k++) step();
    step();
    chk("drain", sbq.size(), 0);
  endtask

  initial begin
    bus.req_vld = '0; bus.req_hash = '0; bus.req_nh_count = '0; bus.req_nh_base = '0;
    bus.resp_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, requests asserted but ignored.
    bus.req_vld = '1;
    #1;
    chk("rst_req_rdy", bus.req_rdy, 0);
    chk("rst_resp_vld", bus.resp_vld, 0);
    chk("rst_resp_nh", bus.resp_nh, 0);
    chk("rst_resp_id", bus.resp_id, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    chk("rst_dividend", bus.div_dividend, 0);
    chk("rst_divisor", bus.div_divisor, 0);
    bus.req_vld = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single request; inputs change after grant must not matter.
    set_req(0, 4'hB, 4'd3, 8'h10);
    bus.req_vld = 4'b0001;
    #1;
    chk("t1_req_rdy", bus.req_rdy, 4'b0001);
    step();
    bus.req_vld = '0;
    set_req(0, 4'h0, 4'h0, 8'h00);
    #1;
    chk("t1_dividend", bus.div_dividend, 4'hB);
    chk("t1_divisor", bus.div_divisor, 4'd3);
    step();
    step();
    #1;
    chk("t1_nh_direct", bus.resp_nh, 8'h12);
    drain();

    // Round robin from a fresh reset.
    reset = 1'b0;
    #1;
    reset = 1'b1;
    prev_vld = 1'b0;
    gnt_ids.delete();
    gnt_cyc.delete();
    set_req(0, 4'h7, 4'd3, 8'h40);
    set_req(1, 4'h9, 4'd4, 8'h50);
    set_req(2, 4'hE, 4'd5, 8'h60);
    set_req(3, 4'h2, 4'd0, 8'h70);
    bus.req_vld = 4'b1111;
    for (int k = 0; k < 40 && gnt_ids.size() < 5; k++) step();
    bus.req_vld = '0;
    drain();
    chk("rr_count", gnt_ids.size(), 5);
    for (int k = 0; k < gnt_ids.size(); k++) chk("rr_order", gnt_ids[k], k % 4);
    for (int k = 1; k < gnt_cyc.size(); k++) chk("rr_spacing", gnt_cyc[k] - gnt_cyc[k-1], 4);

    // Backpressure: response held 5 cycles with all requests pending.
    bus.resp_rdy = 1'b0;
    bus.req_vld  = 4'b0100;
    for (int k = 0; k < 10 && !bus.resp_vld; k++) step();
    chk("bp_vld_seen", bus.resp_vld, 1);
    hold_nh = bus.resp_nh;
    hold_id = bus.resp_id;
    chk("bp_nh_value", hold_nh, 8'h64);
    bus.req_vld = 4'b1111;
    repeat (5) begin
      #1;
      chk("bp_vld", bus.resp_vld, 1);
      chk("bp_nh", bus.resp_nh, hold_nh);
      chk("bp_id", bus.resp_id, hold_id);
      chk("bp_req_rdy", bus.req_rdy, 0);
      step();
    end
    bus.resp_rdy = 1'b1;
    bus.req_vld  = '0;
    step();
    bus.req_vld = 4'b0001;
    #1;
    chk("bp_vld_drop", bus.resp_vld, 0);
    chk("bp_idle_grant", bus.req_rdy, 4'b0001);
    step();
    bus.req_vld = '0;
    drain();

    // Edge values.
    set_req(3, 4'h9, 4'd0, 8'h20);
    bus.req_vld = 4'b1000;
    step();
    bus.req_vld = '0;
    drain();
    set_req(1, 4'h5, 4'd3, 8'hFF);
    bus.req_vld = 4'b0010;
    step();
    bus.req_vld = '0;
    drain();
    frc_en = 1'b1;
    frc_val = 4'hF;
    set_req(2, 4'h3, 4'hC, 8'h33);
    bus.req_vld = 4'b0100;
    step();
    bus.req_vld = '0;
    drain();
    frc_en = 1'b0;

    // Reset during CAPT aborts the transaction.
    bus.req_vld = 4'b0100;
    step();
    bus.req_vld = 4'b1111;
    step();
    reset = 1'b0;
    #1;
    chk("ra_req_rdy", bus.req_rdy, 0);
    chk("ra_resp_vld", bus.resp_vld, 0);
    chk("ra_resp_nh", bus.resp_nh, 0);
    chk("ra_resp_id", bus.resp_id, 0);
    chk("ra_resp_err", bus.resp_err, 0);
    chk("ra_dividend", bus.div_dividend, 0);
    chk("ra_divisor", bus.div_divisor, 0);
    sbq.delete();
    prev_vld = 1'b0;
    bus.req_vld = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) begin
      #1;
      chk("ra_no_resp", bus.resp_vld, 0);
      step();
    end
    bus.req_vld = 4'b1111;
    #1;
    chk("ra_next_gnt", bus.req_rdy, 4'b0001);
    step();
    bus.req_vld = '0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
